// File: rtl/input_event_arbiter_pkg.sv
// Shared types and constants for the debounced input event arbiter.
// Holds the arbiter FSM encoding, event type codes and a counter sizing helper.
package input_event_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam logic EVT_RELEASE = 1'b0;
    localparam logic EVT_PRESS   = 1'b1;

    // Bits needed to count 0 .. cycles-1, never less than one bit.
    function automatic int cntWidth(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_event_arbiter_debounce_channel.sv
// One input channel: two-flop synchronizer, stability counter and debounced level.
// o_changed is a combinational strobe high in the cycle before o_state toggles.
module debounce_channel
    import input_event_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_state,
    output logic o_changed,
    output logic o_newLevel
);

    localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_state;
    logic [CNT_W-1:0] r_count;

    logic w_mismatch;
    logic w_fire;

    assign w_mismatch = r_sync ^ r_state;
    assign w_fire     = w_mismatch && (r_count == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    // The counter never passes CNT_LAST: reaching it with a mismatch flips the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= 1'b0;
            r_count <= '0;
        end else if (w_fire) begin
            r_state <= ~r_state;
            r_count <= '0;
        end else if (w_mismatch) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

    assign o_state    = r_state;
    assign o_changed  = w_fire;
    assign o_newLevel = r_sync;

endmodule

// File: rtl/input_event_arbiter.sv
// Debounces N asynchronous buttons and serialises their press/release events
// through a round-robin arbiter onto a valid/ready event port.
module input_event_arbiter
    import input_event_arbiter_pkg::*;
#(
    parameter int N_INPUTS        = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_INPUTS-1:0]         btn_async,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(N_INPUTS)-1:0] evt_id,
    output logic                        evt_press,
    output logic [N_INPUTS-1:0]         btn_state,
    output logic [N_INPUTS-1:0]         overflow,
    input  logic [N_INPUTS-1:0]         overflow_clr
);

    localparam int ID_W = $clog2(N_INPUTS);
    localparam logic [N_INPUTS-1:0] ONE_HOT0 = N_INPUTS'(1);

    logic [N_INPUTS-1:0] w_changed;
    logic [N_INPUTS-1:0] w_newLevel;
    logic [N_INPUTS-1:0] w_btnState;

    logic [N_INPUTS-1:0] r_pending;
    logic [N_INPUTS-1:0] r_pendType;
    logic [N_INPUTS-1:0] r_overflow;
    logic [ID_W-1:0]     r_lastGrant;
    arb_state_t          r_state;
    logic [ID_W-1:0]     r_evtId;
    logic                r_evtPress;

    logic                w_grantValid;
    logic [ID_W-1:0]     w_grantIdx;
    logic [ID_W-1:0]     w_scanIdx;
    logic                w_take;
    logic [N_INPUTS-1:0] w_grantMask;
    logic [N_INPUTS-1:0] w_overflowSet;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_async    (btn_async[g]),
            .o_state    (w_btnState[g]),
            .o_changed  (w_changed[g]),
            .o_newLevel (w_newLevel[g])
        );
    end

    // Scan starts one past the last grant so every channel gets a turn.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_scanIdx    = '0;
        for (int k = 1; k <= N_INPUTS; k++) begin
            w_scanIdx = ID_W'((int'(r_lastGrant) + k) % N_INPUTS);
            if (!w_grantValid && r_pending[w_scanIdx]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = w_scanIdx;
            end
        end
    end

    assign w_take        = (r_state == IDLE) && w_grantValid;
    assign w_grantMask   = w_take ? (ONE_HOT0 << w_grantIdx) : '0;
    // A channel being granted this cycle has room for a fresh event, so no loss.
    assign w_overflowSet = w_changed & r_pending & ~w_grantMask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_pendType <= '0;
            r_overflow <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_grantMask) | w_changed;
            r_overflow <= (r_overflow & ~overflow_clr) | w_overflowSet;
            for (int ch = 0; ch < N_INPUTS; ch++) begin
                if (w_changed[ch]) begin
                    r_pendType[ch] <= w_newLevel[ch] ? EVT_PRESS : EVT_RELEASE;
                end
            end
        end
    end

    // Leaving OFFER always passes through IDLE, giving one bubble per event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_evtId     <= '0;
            r_evtPress  <= EVT_RELEASE;
            r_lastGrant <= ID_W'(N_INPUTS - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_state     <= OFFER;
                        r_evtId     <= w_grantIdx;
                        r_evtPress  <= r_pendType[w_grantIdx];
                        r_lastGrant <= w_grantIdx;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign evt_valid = (r_state == OFFER);
    assign evt_id    = r_evtId;
    assign evt_press = r_evtPress;
    assign btn_state = w_btnState;
    assign overflow  = r_overflow;

endmodule
